// File: rtl/ysyx_22050133_axi_sram_pkg.sv
// ysyx_22050133_axi_sram_pkg: response codes and FSM state encodings for the AXI SRAM
package ysyx_22050133_axi_sram_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
endpackage

// File: rtl/ysyx_22050133_sram_array.sv
// ysyx_22050133_sram_array: word-addressed storage with byte-strobed write and registered read
module ysyx_22050133_sram_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64,
  parameter int IW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wstrb,
  input  logic                 re,
  input  logic [IW-1:0]        raddr,
  output logic [WIDTH-1:0]     rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  // read register holds its value until the next read; a same-edge write is not visible
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  // storage is deliberately never reset
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < WIDTH/8; i++)
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  // output register clears on reset so r_data reads 0 afterwards
  always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/ysyx_22050133_axi_sram.sv
// ysyx_22050133_axi_sram: single-beat AXI slave over an SRAM with independent read and write FSMs
module ysyx_22050133_axi_sram
  import ysyx_22050133_axi_sram_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
  parameter int                        RD_LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        axi_aw_ready_o,
  input  logic                        axi_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
  output logic                        axi_w_ready_o,
  input  logic                        axi_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                        axi_b_ready_i,
  output logic                        axi_b_valid_o,
  output logic [1:0]                  axi_b_resp_o,
  output logic                        axi_ar_ready_o,
  input  logic                        axi_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic                        axi_r_ready_i,
  output logic                        axi_r_valid_o,
  output logic [1:0]                  axi_r_resp_o,
  output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = RD_LATENCY > 0 ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [AXI_ADDR_WIDTH:0] SPAN = (AXI_ADDR_WIDTH+1)'(MEM_DEPTH * 8);
  function automatic logic hit(input logic [AXI_ADDR_WIDTH-1:0] a);
    return a >= BASE_ADDR && {1'b0, a - BASE_ADDR} < SPAN;
  endfunction
  function automatic logic [IW-1:0] word(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> 3;
    return off[IW-1:0];
  endfunction
  r_state_e r_state_q, r_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] raddr_q, raddr_d;
  logic rok_q, rok_d;
  logic [1:0] r_resp_q, r_resp_d;
  logic re;
  w_state_e w_state_q, w_state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, wa;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d, wd;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d, ws;
  logic [1:0] b_resp_q, b_resp_d;
  logic aw_fire, w_fire, commit, we;
  logic [AXI_DATA_WIDTH-1:0] arr_rdata;
  assign axi_ar_ready_o = r_state_q == R_IDLE;
  assign axi_r_valid_o  = r_state_q == R_RESP;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_data_o   = r_resp_q == RESP_DECERR ? '0 : arr_rdata;
  assign axi_aw_ready_o = w_state_q == W_IDLE && !aw_held_q;
  assign axi_w_ready_o  = w_state_q == W_IDLE && !w_held_q;
  assign axi_b_valid_o  = w_state_q == W_RESP;
  assign axi_b_resp_o   = b_resp_q;
  // read FSM: latch address, count down the latency, fetch the word on the edge entering R_RESP
  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    rok_d     = rok_q;
    r_resp_d  = r_resp_q;
    re        = 1'b0;
    case (r_state_q)
      R_IDLE: if (axi_ar_valid_i) begin
        raddr_d = word(axi_ar_addr_i);
        rok_d   = hit(axi_ar_addr_i);
        cnt_d   = CW'(RD_LATENCY);
        if (RD_LATENCY == 0) begin
          r_state_d = R_RESP;
          re        = rok_d;
          r_resp_d  = rok_d ? RESP_OKAY : RESP_DECERR;
        end else r_state_d = R_WAIT;
      end
      R_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          r_state_d = R_RESP;
          re        = rok_q;
          r_resp_d  = rok_q ? RESP_OKAY : RESP_DECERR;
        end
      end
      default: r_state_d = axi_r_ready_i ? R_IDLE : R_RESP;
    endcase
  end
  // read state registers
  always_ff @(posedge clk)
    if (rst) begin
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
      raddr_q   <= '0;
      rok_q     <= 1'b0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
      raddr_q   <= raddr_d;
      rok_q     <= rok_d;
      r_resp_q  <= r_resp_d;
    end
  // write FSM: collect AW and W in any order, commit as soon as both are present
  always_comb begin
    aw_fire   = axi_aw_valid_i && axi_aw_ready_o;
    w_fire    = axi_w_valid_i && axi_w_ready_o;
    wa        = aw_held_q ? aw_addr_q : axi_aw_addr_i;
    wd        = w_held_q ? w_data_q : axi_w_data_i;
    ws        = w_held_q ? w_strb_q : axi_w_strb_i;
    commit    = w_state_q == W_IDLE && (aw_held_q || aw_fire) && (w_held_q || w_fire);
    we        = commit && hit(wa) && !rst;
    w_state_d = w_state_q;
    aw_held_d = aw_held_q || aw_fire;
    w_held_d  = w_held_q || w_fire;
    aw_addr_d = aw_fire ? axi_aw_addr_i : aw_addr_q;
    w_data_d  = w_fire ? axi_w_data_i : w_data_q;
    w_strb_d  = w_fire ? axi_w_strb_i : w_strb_q;
    b_resp_d  = b_resp_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      w_state_d = W_RESP;
      b_resp_d  = hit(wa) ? RESP_OKAY : RESP_DECERR;
    end
    if (w_state_q == W_RESP && axi_b_ready_i) w_state_d = W_IDLE;
  end
  // write state registers
  always_ff @(posedge clk)
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
    end
  ysyx_22050133_sram_array #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(AXI_DATA_WIDTH),
    .IW   (IW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(word(wa)),
    .wdata(wd),
    .wstrb(ws),
    .re   (re),
    .raddr(raddr_d),
    .rdata(arr_rdata)
  );
endmodule

// File: doc/ysyx_22050133_axi_sram.md
YSYX_22050133_AXI_SRAM -- requirements
Module: ysyx_22050133_axi_sram

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64, data bus width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of 64-bit words stored.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter RD_LATENCY, default 2, wait cycles between AR accept and R valid (0 allowed).
REQ-006 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port axi_aw_ready_o  out  1  write-address ready.
REQ-009 SHALL have port axi_aw_valid_i  in  1  write-address valid.
REQ-010 SHALL have port axi_aw_addr_i  in  AXI_ADDR_WIDTH  write byte address.
REQ-011 SHALL have port axi_w_ready_o  out  1  write-data ready.
REQ-012 SHALL have port axi_w_valid_i  in  1  write-data valid.
REQ-013 SHALL have port axi_w_data_i  in  AXI_DATA_WIDTH  write data.
REQ-014 SHALL have port axi_w_strb_i  in  AXI_DATA_WIDTH/8  byte strobes, bit i enables byte i.
REQ-015 SHALL have port axi_b_ready_i  in  1  write-response ready.
REQ-016 SHALL have port axi_b_valid_o  out  1  write-response valid.
REQ-017 SHALL have port axi_b_resp_o  out  2  write response.
REQ-018 SHALL have port axi_ar_ready_o  out  1  read-address ready.
REQ-019 SHALL have port axi_ar_valid_i  in  1  read-address valid.
REQ-020 SHALL have port axi_ar_addr_i  in  AXI_ADDR_WIDTH  read byte address.
REQ-021 SHALL have port axi_r_ready_i  in  1  read-data ready.
REQ-022 SHALL have port axi_r_valid_o  out  1  read-data valid.
REQ-023 SHALL have port axi_r_resp_o  out  2  read response.
REQ-024 SHALL have port axi_r_data_o  out  AXI_DATA_WIDTH  read data.

Function
REQ-025 SHALL serve single-beat transactions only; read and write FSMs SHALL run independently and concurrently.
REQ-026 SHALL decode address in range iff BASE_ADDR <= addr < BASE_ADDR+MEM_DEPTH*8; word index = (addr-BASE_ADDR)>>3; addr[2:0] ignored.
REQ-027 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; axi_ar_ready_o=1 only in R_IDLE.
REQ-028 On AR handshake in cycle T, SHALL latch address and load counter with RD_LATENCY; go to R_WAIT, or directly R_RESP if RD_LATENCY=0.
REQ-029 In R_WAIT SHALL decrement counter each cycle and enter R_RESP when it reaches 0, so axi_r_valid_o first asserts in cycle T+1+RD_LATENCY.
REQ-030 SHALL latch read data on the edge entering R_RESP and hold r_valid/r_data/r_resp stable until r_ready; on R handshake SHALL return to R_IDLE (next AR accepted one cycle later earliest).
REQ-031 In-range read SHALL return resp 2'b00 with stored word; out-of-range read SHALL return resp 2'b11, data 0.
REQ-032 Write FSM SHALL have states W_IDLE, W_RESP; in W_IDLE axi_aw_ready_o=!aw_held and axi_w_ready_o=!w_held, AW and W accepted in either order or same cycle.
REQ-033 Once both AW and W are held (or arrive), on the next edge SHALL commit strobed bytes to memory, clear held flags, enter W_RESP with axi_b_valid_o=1.
REQ-034 In-range write SHALL give b_resp 2'b00; out-of-range write SHALL not modify memory and give 2'b11; strb=0 SHALL give 2'b00 with no change.
REQ-035 SHALL hold b_valid/b_resp until b_ready; on B handshake return to W_IDLE, both readies 0 in W_RESP.
REQ-036 Read latch and write commit to the same word on the same edge SHALL return the old (pre-write) data.

Reset
REQ-037 On rst SHALL force R_IDLE, W_IDLE, held flags 0, counter 0, all valid outputs 0, resp 0, r_data 0; readies follow state (ar/aw/w ready=1 the cycle after rst drops).
REQ-038 Reset mid-transaction SHALL abandon it without response; memory contents SHALL NOT be reset or altered.

Structure
REQ-039 Shared package SHALL hold resp codes RESP_OKAY=2'b00, RESP_DECERR=2'b11 and read/write FSM state encodings.
REQ-040 Storage SHALL be sub-module ysyx_22050133_sram_array (MEM_DEPTH x 64, byte-strobe write port, registered read port).

Verification
REQ-041 Write 0x8000_0008 data 0x1122334455667788 strb 0xFF, then read it -> b_resp 0, r_data 0x1122334455667788, r_valid at T+3.
REQ-042 W issued 2 cycles before AW, strb 0x0F data 0xFFFF_FFFF_FFFF_FFFF over 0x1122334455667788 -> read 0x11223344FFFFFFFF.
REQ-043 Read 0x7FFF_FFF8 and write 0x8000_2000 -> r_resp 2'b11 data 0, b_resp 2'b11, word 0 unchanged.
REQ-044 r_ready held low 5 cycles in R_RESP -> r_valid/r_data stable all 5 cycles, ar_ready 0 until handshake.
REQ-045 Simultaneous read latch and write commit to 0x8000_0010 (old 0xA, new 0xB) -> read returns 0xA, subsequent read 0xB.
REQ-046 rst asserted during R_WAIT -> next cycle r_valid 0, ar_ready 1; memory unchanged.
